prod_accumulator: RTL and testbench
===================================

# prod_accumulator

Downstream consumer of the 8x8 Wallace multiplier's 17-bit product `p`: accumulates a programmable number of unsigned products into a dot-product result, with unsigned saturation. It sits between the combinational multiplier and the result bus. Products enter via a valid/ready handshake; each finished sum leaves through a one-entry valid/ready output buffer.

## Interface
- `WIDTH`, 8: multiplier operand width; product width `PROD_W = 2*WIDTH+1` (17).
- `ACC_W`, 24: accumulator/result width; must be ≥ `PROD_W`.
- `CNT_W`, 8: term-count width.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `clr  in  1`: synchronous abort; drops the partial sum and any pending result.
- `prod_in  in  PROD_W`: product from the multiplier's `p`.
- `prod_valid  in  1`: `prod_in` holds a valid term.
- `prod_ready  out  1`: the block can accept a term this cycle.
- `len  in  CNT_W`: terms per block, sampled on the first term of each block; 0 means 2^CNT_W.
- `acc_out  out  ACC_W`: finished sum.
- `acc_valid  out  1`: `acc_out` holds a result.
- `acc_ready  in  1`: downstream takes the result.
- `ovf  out  1`: the current result saturated; qualified by `acc_valid`.
- `busy  out  1`: a block is partially accumulated (state ACCUM).

## Operation
- A term transfer occurs on `prod_valid & prod_ready`. A result transfer occurs on `acc_valid & acc_ready`.
- States:
  - **IDLE**: no block open.
  - **ACCUM**: block open, terms remaining > 0.
  - **HOLD**: result pending in the output buffer.
- **IDLE**, on a term transfer:
  - `sum <= prod_in`, `rem <= len-1` (modulo 2^CNT_W, so `len=0` gives 255 remaining), `ovf_i <= 0`.
  - Go to HOLD if `len==1`, else ACCUM.
- **ACCUM**, on a term transfer:
  - `sum <= sat(sum + prod_in)`, `rem <= rem-1`.
  - Go to HOLD when `rem` was 1.
  - Cycles without a transfer hold all state.
- **HOLD**:
  - `acc_valid=1`.
  - `acc_out` and `ovf` stay stable until the result transfer.
  - On the result transfer, go to IDLE. If a term transfer happens in the same cycle, treat it as an IDLE first-term transfer and go to ACCUM or HOLD accordingly.
- `prod_ready = !rst & (state != HOLD | acc_ready)`. This gives a combinational path from `acc_ready` to `prod_ready`, which is intended.
- Arithmetic and saturation:
  - Unsigned addition, computed `ACC_W+1` bits wide.
  - On carry-out, `sum` becomes all ones and `ovf_i` is set.
  - `ovf_i` is sticky until the next block starts.
  - `prod_in` is zero-extended to `ACC_W`.
- `clr`:
  - Highest priority; next state is IDLE, `sum` is zeroed, and `acc_valid` drops.
  - A term presented in the `clr` cycle is not accepted: `prod_ready` behaves normally, but the transfer is discarded.
- `len` changes mid-block are ignored.

## Timing
- Reset values: state IDLE, `acc_out=0`, `acc_valid=0`, `ovf=0`, `busy=0`, `prod_ready=0` while `rst` is high.
- Reset mid-block or mid-HOLD discards everything. The first term after deassertion starts a new block.
- Throughput is one term per cycle.
- `acc_valid` rises on the clock edge that accepts the block's last term, so the result is visible one cycle after the last term.
- Back-to-back blocks run with zero bubbles when `acc_ready` is held high.
- If `acc_ready` is low in HOLD, upstream stalls (`prod_ready=0`) with no term loss.
- All outputs are registered except `prod_ready`.

## Structure
- Shared package `mult_pkg` holds:
  - `WIDTH`, `PROD_W`, `ACC_W`, `CNT_W` constants.
  - `acc_state_t` enum {IDLE, ACCUM, HOLD}.
- One sub-module, `sat_add`: combinational `ACC_W`-bit unsigned saturating adder with outputs `sum` and `sat`. It is reusable by later MAC stages.
- The multiplier is instantiated by the parent, not inside this block.

## Test plan
- **Single-term block:** `len=1`, term 65025, `acc_ready=1` → `acc_out=65025`, `acc_valid` high for one cycle, `ovf=0`.
- **Four-term block:** `len=4`, terms 10,20,30,40 on consecutive cycles → `acc_out=100` one cycle after the 4th term. `busy` is high for 3 cycles.
- **Stall and bypass:** `len=2`, hold `acc_ready=0` for 5 cycles after the result, with `prod_valid` held → `prod_ready=0` and `acc_out` stable. Then raise `acc_ready` → result transfer and next first term accepted in the same cycle.
- **Saturation:** `ACC_W=17`, `len=3`, terms 65025 ×3 → `acc_out=0x1FFFF`, `ovf=1`. The next block with `len=1` and term 5 gives `ovf=0`.
- **`len=0` and `clr`:** `len=0`, 256 terms of value 1 → `acc_out=256`. Then a 3-term block is started and `clr` is pulsed after 2 terms → no result, and the following block starts fresh.
- **Asynchronous reset:** `rst` asserted mid-ACCUM between clock edges → all outputs immediately at reset values, and a new block after release sums correctly.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and types for the multiplier / product-accumulation datapath.
//   WIDTH  : multiplier operand width
//   PROD_W : multiplier product width (2*WIDTH+1)
//   ACC_W  : accumulator / result width (>= PROD_W)
//   CNT_W  : term-count width
//   acc_state_t : accumulator control states
package mult_pkg;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned PROD_W = 2 * WIDTH + 1;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_t;

endpackage

// File: rtl/sat_add.sv
// Combinational W-bit unsigned saturating adder.
//   i_a, i_b : addends
//   sum      : a+b, or all ones when the true sum does not fit in W bits
//   sat      : carry-out of the W-bit addition (result clamped)
module sat_add #(
  parameter int unsigned W = mult_pkg::ACC_W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] sum,
  output logic         sat
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign sat    = w_full[W];
  assign sum    = w_full[W] ? '1 : w_full[W-1:0];

endmodule

// File: rtl/prod_accumulator.sv
// Accumulates a programmable number of unsigned multiplier products into one
// saturating dot-product result, delivered through a one-entry output buffer.
//   clk, rst            : clock, asynchronous active-high reset
//   clr                 : synchronous abort of partial sum and pending result
//   prod_in/valid/ready : product input handshake
//   len                 : terms per block, sampled on a block's first term (0 = 2^CNT_W)
//   acc_out/valid/ready : result output handshake
//   ovf                 : result saturated (qualified by acc_valid)
//   busy                : block partially accumulated
module prod_accumulator #(
  parameter  int unsigned WIDTH  = mult_pkg::WIDTH,
  parameter  int unsigned ACC_W  = mult_pkg::ACC_W,
  parameter  int unsigned CNT_W  = mult_pkg::CNT_W,
  localparam int unsigned PROD_W = 2 * WIDTH + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [CNT_W-1:0]  len,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              ovf,
  output logic              busy
);

  import mult_pkg::*;

  acc_state_t       r_state, w_state_d;
  logic [ACC_W-1:0] r_sum, w_sum_d;
  logic [CNT_W-1:0] r_rem, w_rem_d;
  logic             r_ovf, w_ovf_d;

  logic             w_term;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_add_sum;
  logic             w_add_sat;

  // Combinational from acc_ready on purpose: lets a pending result drain and
  // the next block's first term enter in the same cycle.
  assign prod_ready = !rst && ((r_state != HOLD) || acc_ready);
  assign w_term     = prod_valid && prod_ready;
  assign w_prod_ext = ACC_W'(prod_in);

  sat_add #(
    .W(ACC_W)
  ) u_sat_add (
    .i_a (r_sum),
    .i_b (w_prod_ext),
    .sum (w_add_sum),
    .sat (w_add_sat)
  );

  always_comb begin
    w_state_d = r_state;
    w_sum_d   = r_sum;
    w_rem_d   = r_rem;
    w_ovf_d   = r_ovf;

    if (clr) begin
      w_state_d = IDLE;
      w_sum_d   = '0;
      w_rem_d   = '0;
      w_ovf_d   = 1'b0;
    end else begin
      unique case (r_state)
        IDLE, HOLD: begin
          // HOLD only reopens once its result is taken.
          if (r_state == HOLD && acc_ready) begin
            w_state_d = IDLE;
          end
          if (w_term) begin
            w_sum_d   = w_prod_ext;
            // len=0 wraps to all ones, giving 2^CNT_W terms.
            w_rem_d   = len - CNT_W'(1);
            w_ovf_d   = 1'b0;
            w_state_d = (len == CNT_W'(1)) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (w_term) begin
            w_sum_d = w_add_sum;
            w_ovf_d = r_ovf || w_add_sat;
            w_rem_d = r_rem - CNT_W'(1);
            if (r_rem == CNT_W'(1)) begin
              w_state_d = HOLD;
            end
          end
        end
        default: w_state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sum   <= '0;
      r_rem   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_sum   <= w_sum_d;
      r_rem   <= w_rem_d;
      r_ovf   <= w_ovf_d;
    end
  end

  assign acc_out   = r_sum;
  assign acc_valid = (r_state == HOLD);
  assign ovf       = r_ovf;
  assign busy      = (r_state == ACCUM);

endmodule

// File: tb/tb_prod_accumulator.sv
module tb_prod_accumulator;

  localparam int MI = 0;
  localparam int MA = 1;
  localparam int MH = 2;
  localparam int MAX24 = (1 << 24) - 1;
  localparam int MAX17 = (1 << 17) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [16:0] prod_in;
  logic        prod_valid;
  logic [7:0]  len;
  logic        acc_ready;

  logic        prod_ready, acc_valid, ovf, busy;
  logic [23:0] acc_out;
  logic        prod_ready17, acc_valid17, ovf17, busy17;
  logic [16:0] acc_out17;

  prod_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .len        (len),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .ovf        (ovf),
    .busy       (busy)
  );

  prod_accumulator #(
    .ACC_W(17)
  ) dut17 (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready17),
    .len        (len),
    .acc_out    (acc_out17),
    .acc_valid  (acc_valid17),
    .acc_ready  (acc_ready),
    .ovf        (ovf17),
    .busy       (busy17)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   s24;
    logic o24;
    int   s17;
    logic o17;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model of the block protocol.
  int   m_state = MI;
  int   m_rem = 0;
  int   m_s24 = 0;
  int   m_s17 = 0;
  logic m_o24 = 1'b0;
  logic m_o17 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = MI;
    m_rem   = 0;
    m_s24   = 0;
    m_s17   = 0;
    m_o24   = 1'b0;
    m_o17   = 1'b0;
    q.delete();
  endtask

  task automatic enter_hold();
    exp_t e;
    e.s24 = m_s24;
    e.o24 = m_o24;
    e.s17 = m_s17;
    e.o17 = m_o17;
    q.push_back(e);
    m_state = MH;
  endtask

  // Called at posedge+1 with inputs set; checks outputs, advances one cycle.
  task automatic step();
    logic exp_rdy, term, res;
    int   v;
    #1;
    exp_rdy = (m_state != MH) || acc_ready;
    check("prod_ready", prod_ready, exp_rdy);
    check("prod_ready17", prod_ready17, exp_rdy);
    check("acc_valid", acc_valid, m_state == MH);
    check("acc_valid17", acc_valid17, m_state == MH);
    check("busy", busy, m_state == MA);
    if (m_state == MH) begin
      if (q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        check("acc_out", acc_out, q[0].s24);
        check("ovf", ovf, q[0].o24);
        check("acc_out17", acc_out17, q[0].s17);
        check("ovf17", ovf17, q[0].o17);
      end
    end
    term = prod_valid && exp_rdy && !clr;
    res  = (m_state == MH) && acc_ready;
    v    = int'(prod_in);
    if (clr) begin
      if (m_state == MH && q.size() > 0) void'(q.pop_front());
      m_state = MI;
      m_s24 = 0;
      m_s17 = 0;
    end else begin
      if (res) begin
        if (q.size() > 0) void'(q.pop_front());
        m_state = MI;
      end
      if (term) begin
        if (m_state == MA) begin
          m_s24 += v;
          if (m_s24 > MAX24) begin m_s24 = MAX24; m_o24 = 1'b1; end
          m_s17 += v;
          if (m_s17 > MAX17) begin m_s17 = MAX17; m_o17 = 1'b1; end
          m_rem--;
          if (m_rem == 0) enter_hold();
        end else begin
          m_s24 = v;
          m_s17 = v;
          m_o24 = 1'b0;
          m_o17 = 1'b0;
          m_rem = ((len == 8'd0) ? 256 : int'(len)) - 1;
          if (m_rem == 0) enter_hold();
          else m_state = MA;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic term_in(input int v, input int l);
    prod_valid = 1'b1;
    prod_in    = 17'(v);
    len        = 8'(l);
    step();
  endtask

  task automatic idle();
    prod_valid = 1'b0;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acc_out"}, acc_out, 0);
    check({tag, "_acc_valid"}, acc_valid, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_prod_ready"}, prod_ready, 0);
    check({tag, "_acc_out17"}, acc_out17, 0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; prod_in = '0; prod_valid = 1'b0; len = 8'd1; acc_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    prod_valid = 1'b1;
    #1;
    check_reset_outputs("reset");
    prod_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-term block.
    term_in(65025, 1);
    idle();
    idle();

    // Four-term block, busy for three cycles.
    term_in(10, 4);
    term_in(20, 4);
    term_in(30, 4);
    term_in(40, 4);
    idle();
    idle();

    // Stall with prod_valid held, then bypass.
    term_in(7, 2);
    term_in(9, 2);
    acc_ready = 1'b0;
    prod_valid = 1'b1; prod_in = 17'd3; len = 8'd1;
    repeat (5) step();
    acc_ready = 1'b1;
    step();
    idle();
    idle();

    // Saturation in the 17-bit instance, then a fresh block clears ovf.
    repeat (3) term_in(65025, 3);
    idle();
    term_in(5, 1);
    idle();
    idle();

    // len=0 means 256 terms.
    for (int i = 0; i < 256; i++) term_in(1, 0);
    idle();
    idle();

    // clr after two terms of a three-term block; term in the clr cycle is dropped.
    term_in(4, 3);
    term_in(5, 3);
    clr = 1'b1;
    term_in(6, 3);
    clr = 1'b0;
    idle();
    term_in(2, 2);
    term_in(3, 2);
    idle();
    idle();

    // Asynchronous reset between edges in the middle of a block.
    term_in(50, 4);
    term_in(60, 4);
    prod_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    term_in(11, 2);
    term_in(22, 2);
    idle();
    idle();

    check("scoreboard_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
